set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter NUM_SET, 4, number of sets (power of two, >=2).
REQ-002 SHALL have parameter NUM_WAY, 2, ways per set (power of two, >=2).
REQ-003 SHALL have parameter DATA_WIDTH, 32, word width; ADDR_WIDTH fixed 32.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid input 1, req_we input 1, req_addr input 32, req_wdata input DATA_WIDTH: CPU request (ALUResultM/WriteDataM/MemWriteM source).
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-008 SHALL have ports rsp_valid output 1, rsp_rdata output DATA_WIDTH, hit output 1: response, hit flag of that request.
REQ-009 SHALL have ports mem_req_valid output 1, mem_req_we output 1, mem_req_addr output 32, mem_req_wdata output DATA_WIDTH, mem_req_ready input 1: backing-memory request.
REQ-010 SHALL have ports mem_rsp_valid input 1, mem_rsp_rdata input DATA_WIDTH: backing-memory read return.

Function
REQ-011 SHALL split req_addr: offset [1:0] ignored, index [clog2(NUM_SET)+1:2], tag = remaining upper bits; one word per line.
REQ-012 SHALL store per way: valid, dirty, tag, data, age (clog2(NUM_WAY) bits).
REQ-013 SHALL detect hit combinationally in cycle of acceptance; at most one way matches.
REQ-014 SHALL, on read hit, assert rsp_valid, hit=1, rsp_rdata=line data exactly one cycle after acceptance.
REQ-015 SHALL, on write hit, update data, set dirty, assert rsp_valid, hit=1 next cycle (rsp_rdata = written value).
REQ-016 SHALL select victim: lowest-index invalid way; else way with maximum age (true LRU).
REQ-017 SHALL, on every access completion, set accessed way age 0 and increment ages of valid ways in set with age below its old age.
REQ-018 SHALL run FSM IDLE, WB, REFILL, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL, on miss with dirty victim, go IDLE->WB: mem_req_we=1, addr={victim tag,index,2'b00}, wdata=victim data; leave WB on mem_req_ready.
REQ-020 SHALL, after WB or on clean-victim miss: read miss -> REFILL (mem_req_we=0, request address); write miss -> RESP (write-allocate, no fetch).
REQ-021 SHALL, in REFILL, drop mem_req_valid after mem_req_ready, wait mem_rsp_valid, install line (valid=1, dirty=0), go RESP.
REQ-022 SHALL, in RESP, install write-miss data dirty=1, assert rsp_valid with hit=0, return to IDLE.
REQ-023 SHALL hold mem_req_* stable while mem_req_valid && !mem_req_ready.
REQ-024 SHALL ignore mem_rsp_valid outside REFILL and req_valid outside IDLE.
REQ-025 SHALL support back-to-back hits: one accepted request per cycle.

Reset
REQ-026 SHALL clear all valid, dirty, age bits; FSM=IDLE; rsp_valid=0, hit=0, rsp_rdata=0, mem_req_valid=0, mem_req_we=0; req_ready=1 after reset.
REQ-027 SHALL abandon any in-flight miss on reset with no response produced; tag/data arrays need no reset.

Structure
REQ-028 SHALL place FSM state enum and address-field width functions in shared package cache_pkg.
REQ-029 SHALL implement LRU victim select/age update in sub-module cache_lru (one set, NUM_WAY wide).

Verification (NUM_SET=4, NUM_WAY=2)
REQ-030 SHALL check: reset, read 0x10 -> REFILL read 0x10, mem returns 0xAAAA -> rsp hit=0 0xAAAA; reread -> hit=1 0xAAAA after 1 cycle.
REQ-031 SHALL check: write 0x20=0x1234 then read 0x20 -> no memory traffic, hit=1, 0x1234.
REQ-032 SHALL check LRU: fill 0x00,0x10 in set 0, read 0x00, access 0x20 -> evicts 0x10 way.
REQ-033 SHALL check dirty eviction: write 0x00=0x55, 0x10=0x66, read 0x20 -> WB addr 0x00 data 0x55 before REFILL 0x20.
REQ-034 SHALL check mem_req_ready held low 5 cycles -> mem_req_* stable, req_ready=0.
REQ-035 SHALL check rst during REFILL -> all outputs reset values, subsequent read 0x10 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: controller state
// encoding and helpers deriving address-field widths from the geometry.
package cache_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2,
        ST_RESP   = 2'd3
    } cache_state_t;

    // Index bits selecting one of num_set sets.
    function automatic int idx_width(input int num_set);
        return $clog2(num_set);
    endfunction

    // Tag bits: everything above the index and the 2-bit byte offset.
    function automatic int tag_width(input int num_set);
        return ADDR_WIDTH - 2 - $clog2(num_set);
    endfunction

    // Way-number bits, also the width of a per-way LRU age.
    function automatic int way_width(input int num_way);
        return $clog2(num_way);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU helper for one set: picks a victim way and computes the ages
// that result from touching one way.
module cache_lru
    import cache_pkg::*;
#(
    parameter  int NUM_WAY = 2,
    localparam int WAY_W   = way_width(NUM_WAY)
) (
    input  logic [NUM_WAY-1:0]       valid,
    input  logic [NUM_WAY*WAY_W-1:0] age,
    input  logic [WAY_W-1:0]         acc_way,
    input  logic                     acc_fill,
    output logic [WAY_W-1:0]         victim,
    output logic [NUM_WAY*WAY_W-1:0] new_age
);

    logic [WAY_W-1:0] age_a_s [NUM_WAY];
    logic             inv_found_s;
    logic [WAY_W-1:0] inv_way_s;
    logic [WAY_W-1:0] lru_way_s;
    logic [WAY_W-1:0] lru_age_s;
    logic [WAY_W-1:0] old_age_s;

    // Unpack the flat age vector into per-way entries
    always_comb begin
        for (int w = 0; w < NUM_WAY; w++) begin
            age_a_s[w] = age[w*WAY_W +: WAY_W];
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        lru_way_s   = '0;
        lru_age_s   = age_a_s[0];
        // Descending scan so the lowest invalid index is the one kept
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            inv_found_s = inv_found_s | ~valid[w];
            inv_way_s   = valid[w] ? inv_way_s : WAY_W'(w);
        end
        // Strict compare keeps the lowest index on a tie
        for (int w = 1; w < NUM_WAY; w++) begin
            lru_way_s = (age_a_s[w] > lru_age_s) ? WAY_W'(w) : lru_way_s;
            lru_age_s = (age_a_s[w] > lru_age_s) ? age_a_s[w] : lru_age_s;
        end
        victim = inv_found_s ? inv_way_s : lru_way_s;
    end

    // Touched way becomes youngest; younger valid ways age by one.
    // A freshly filled way counts as having been the oldest so that every
    // other valid way moves up behind it.
    always_comb begin
        old_age_s = acc_fill ? {WAY_W{1'b1}} : age_a_s[acc_way];
        new_age   = '0;
        for (int w = 0; w < NUM_WAY; w++) begin
            if (WAY_W'(w) == acc_way) begin
                new_age[w*WAY_W +: WAY_W] = '0;
            end else if (valid[w] && (age_a_s[w] < old_age_s)) begin
                new_age[w*WAY_W +: WAY_W] = age_a_s[w] + WAY_W'(1'b1);
            end else begin
                new_age[w*WAY_W +: WAY_W] = age_a_s[w];
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Set-associative write-back, write-allocate cache with one word per line,
// true-LRU replacement and a single outstanding backing-memory request.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int NUM_SET    = 4,
    parameter int NUM_WAY    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  hit,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

    localparam int IDX_W = idx_width(NUM_SET);
    localparam int TAG_W = tag_width(NUM_SET);
    localparam int WAY_W = way_width(NUM_WAY);

    cache_state_t state_r;

    // Line storage; only the metadata needs a reset value
    logic [NUM_WAY-1:0]       valid_r [NUM_SET];
    logic [NUM_WAY-1:0]       dirty_r [NUM_SET];
    logic [NUM_WAY*WAY_W-1:0] age_r   [NUM_SET];
    logic [TAG_W-1:0]         tag_r   [NUM_SET][NUM_WAY];
    logic [DATA_WIDTH-1:0]    data_r  [NUM_SET][NUM_WAY];

    // Miss context captured at acceptance (word address only)
    logic [ADDR_WIDTH-1:2]    lat_addr_r;
    logic                     lat_we_r;
    logic [DATA_WIDTH-1:0]    lat_wdata_r;
    logic [WAY_W-1:0]         lat_way_r;

    logic [IDX_W-1:0]         req_idx_s;
    logic [TAG_W-1:0]         req_tag_s;
    logic [IDX_W-1:0]         lat_idx_s;
    logic [TAG_W-1:0]         lat_tag_s;
    logic                     accept_s;
    logic                     hit_s;
    logic [WAY_W-1:0]         hit_way_s;
    logic                     rsp_ok_s;
    logic [IDX_W-1:0]         lru_set_s;
    logic [WAY_W-1:0]         lru_way_s;
    logic                     lru_fill_s;
    logic                     age_upd_s;
    logic [WAY_W-1:0]         victim_s;
    logic [NUM_WAY*WAY_W-1:0] new_age_s;
    logic                     wr_en_s;
    logic [IDX_W-1:0]         wr_set_s;
    logic [WAY_W-1:0]         wr_way_s;
    logic [TAG_W-1:0]         wr_tag_s;
    logic [DATA_WIDTH-1:0]    wr_data_s;
    logic                     wr_dirty_s;
    logic                     unused_ok;

    assign req_idx_s = req_addr[IDX_W+1:2];
    assign req_tag_s = req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign lat_idx_s = lat_addr_r[IDX_W+1:2];
    assign lat_tag_s = lat_addr_r[ADDR_WIDTH-1:IDX_W+2];
    assign req_ready = (state_r == ST_IDLE);
    assign accept_s  = req_valid && (state_r == ST_IDLE);
    // Refill data counts once the read request has been handed off
    assign rsp_ok_s  = (state_r == ST_REFILL) && mem_rsp_valid &&
                       (!mem_req_valid || mem_req_ready);
    // Byte offset is not used by a word-per-line cache
    assign unused_ok = &{1'b0, req_addr[1:0]};

    // Tag compare across the ways of the requested set
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < NUM_WAY; w++) begin
            hit_s     = hit_s | (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s));
            hit_way_s = (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) ?
                        WAY_W'(w) : hit_way_s;
        end
    end

    // LRU operand select: completing miss in RESP, else the incoming request
    always_comb begin
        if (state_r == ST_RESP) begin
            lru_set_s  = lat_idx_s;
            lru_way_s  = lat_way_r;
            lru_fill_s = 1'b1;
            age_upd_s  = 1'b1;
        end else begin
            lru_set_s  = req_idx_s;
            lru_way_s  = hit_way_s;
            lru_fill_s = 1'b0;
            age_upd_s  = accept_s && hit_s;
        end
    end

    cache_lru #(
        .NUM_WAY (NUM_WAY)
    ) u_lru (
        .valid    (valid_r[lru_set_s]),
        .age      (age_r[lru_set_s]),
        .acc_way  (lru_way_s),
        .acc_fill (lru_fill_s),
        .victim   (victim_s),
        .new_age  (new_age_s)
    );

    // Single line write port: write hit, refill install or write-miss install
    always_comb begin
        wr_en_s    = 1'b0;
        wr_set_s   = req_idx_s;
        wr_way_s   = hit_way_s;
        wr_tag_s   = req_tag_s;
        wr_data_s  = req_wdata;
        wr_dirty_s = 1'b1;
        if (accept_s && hit_s && req_we) begin
            wr_en_s = 1'b1;
        end else if (rsp_ok_s) begin
            wr_en_s    = 1'b1;
            wr_set_s   = lat_idx_s;
            wr_way_s   = lat_way_r;
            wr_tag_s   = lat_tag_s;
            wr_data_s  = mem_rsp_rdata;
            wr_dirty_s = 1'b0;
        end else if ((state_r == ST_RESP) && lat_we_r) begin
            wr_en_s   = 1'b1;
            wr_set_s  = lat_idx_s;
            wr_way_s  = lat_way_r;
            wr_tag_s  = lat_tag_s;
            wr_data_s = lat_wdata_r;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Valid, dirty and age bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SET; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                age_r[s]   <= '0;
            end
        end else begin
            if (age_upd_s) begin
                age_r[lru_set_s] <= new_age_s;
            end
            if (wr_en_s) begin
                valid_r[wr_set_s][wr_way_s] <= 1'b1;
                dirty_r[wr_set_s][wr_way_s] <= wr_dirty_s;
            end
        end
    end

    // Tag and data arrays
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_r[wr_set_s][wr_way_s]  <= wr_tag_s;
            data_r[wr_set_s][wr_way_s] <= wr_data_s;
        end
    end

    // Controller FSM with registered response and memory-request outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            rsp_valid     <= 1'b0;
            hit           <= 1'b0;
            rsp_rdata     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            lat_addr_r    <= '0;
            lat_we_r      <= 1'b0;
            lat_wdata_r   <= '0;
            lat_way_r     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (hit_s) begin
                            rsp_valid <= 1'b1;
                            hit       <= 1'b1;
                            rsp_rdata <= req_we ? req_wdata : data_r[req_idx_s][hit_way_s];
                        end else begin
                            lat_addr_r  <= req_addr[ADDR_WIDTH-1:2];
                            lat_we_r    <= req_we;
                            lat_wdata_r <= req_wdata;
                            lat_way_r   <= victim_s;
                            if (valid_r[req_idx_s][victim_s] && dirty_r[req_idx_s][victim_s]) begin
                                state_r       <= ST_WB;
                                mem_req_valid <= 1'b1;
                                mem_req_we    <= 1'b1;
                                mem_req_addr  <= {tag_r[req_idx_s][victim_s], req_idx_s, 2'b00};
                                mem_req_wdata <= data_r[req_idx_s][victim_s];
                            end else if (req_we) begin
                                state_r <= ST_RESP;
                            end else begin
                                state_r       <= ST_REFILL;
                                mem_req_valid <= 1'b1;
                                mem_req_we    <= 1'b0;
                                mem_req_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            end
                        end
                    end
                end
                ST_WB: begin
                    if (mem_req_ready) begin
                        mem_req_we <= 1'b0;
                        if (lat_we_r) begin
                            mem_req_valid <= 1'b0;
                            state_r       <= ST_RESP;
                        end else begin
                            mem_req_addr <= {lat_addr_r, 2'b00};
                            state_r      <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_req_valid && mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                    if (rsp_ok_s) begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    hit       <= 1'b0;
                    rsp_rdata <= lat_we_r ? lat_wdata_r : data_r[lat_idx_s][lat_way_r];
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache (4 sets, 2 ways).
module tb_set_assoc_cache;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        hit;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int          n_checks;
    int          n_errors;

    // Log of accepted memory requests
    int          log_cnt;
    logic        log_we    [32];
    logic [31:0] log_addr  [32];
    logic [31:0] log_wdata [32];

    set_assoc_cache #(
        .NUM_SET    (4),
        .NUM_WAY    (2),
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .hit           (hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'h0000_AAAA : (32'hB000_0000 | a);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Backing memory: samples the handshake just after each falling edge,
    // returns read data for one cycle after the accepting rising edge.
    initial begin
        logic        pend_rd;
        logic [31:0] pend_addr;
        pend_rd       = 1'b0;
        pend_addr     = 32'h0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (pend_rd && !rst) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = mem_word(pend_addr);
            end
            pend_rd = 1'b0;
            #2;
            if (mem_req_valid && mem_req_ready && !rst) begin
                if (log_cnt < 32) begin
                    log_we[log_cnt]    = mem_req_we;
                    log_addr[log_cnt]  = mem_req_addr;
                    log_wdata[log_cnt] = mem_req_wdata;
                end
                log_cnt++;
                if (!mem_req_we) begin
                    pend_rd   = 1'b1;
                    pend_addr = mem_req_addr;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        log_cnt = 0;
    endtask

    // One request; returns hit flag, data and cycles from acceptance to response
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic got_hit, output logic [31:0] got_data, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check_val("rsp_seen", {31'h0, rsp_valid}, 32'h1);
        got_hit  = hit;
        got_data = rsp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        h;
        logic [31:0] d;
        int          lat;
        n_checks      = 0;
        n_errors      = 0;
        log_cnt       = 0;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mem_req_ready = 1'b1;

        // Reset state
        do_reset();
        check_val("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check_val("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("rst_hit", {31'h0, hit}, 32'h0);
        check_val("rst_rdata", rsp_rdata, 32'h0);
        check_val("rst_mem_valid", {31'h0, mem_req_valid}, 32'h0);
        check_val("rst_mem_we", {31'h0, mem_req_we}, 32'h0);

        // Read miss with refill, then read hit one cycle after acceptance
        do_req(1'b0, 32'h10, 32'h0, h, d, lat);
        check_val("miss10_hit", {31'h0, h}, 32'h0);
        check_val("miss10_data", d, 32'h0000_AAAA);
        check_val("miss10_memcnt", log_cnt, 32'd1);
        check_val("miss10_memwe", {31'h0, log_we[0]}, 32'h0);
        check_val("miss10_memaddr", log_addr[0], 32'h10);
        do_req(1'b0, 32'h10, 32'h0, h, d, lat);
        check_val("hit10_hit", {31'h0, h}, 32'h1);
        check_val("hit10_data", d, 32'h0000_AAAA);
        check_val("hit10_lat", lat, 32'd1);
        check_val("hit10_memcnt", log_cnt, 32'd1);

        // Write-allocate miss with no fetch, then read hit
        do_req(1'b1, 32'h20, 32'h1234, h, d, lat);
        check_val("wmiss20_hit", {31'h0, h}, 32'h0);
        check_val("wmiss20_data", d, 32'h1234);
        check_val("wmiss20_memcnt", log_cnt, 32'd1);
        do_req(1'b0, 32'h20, 32'h0, h, d, lat);
        check_val("hit20_hit", {31'h0, h}, 32'h1);
        check_val("hit20_data", d, 32'h1234);
        check_val("hit20_memcnt", log_cnt, 32'd1);

        // Back-to-back hits, one accepted per cycle
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        @(negedge clk);
        check_val("b2b_a_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("b2b_a_hit", {31'h0, hit}, 32'h1);
        check_val("b2b_a_data", rsp_rdata, 32'h0000_AAAA);
        req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("b2b_b_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("b2b_b_hit", {31'h0, hit}, 32'h1);
        check_val("b2b_b_data", rsp_rdata, 32'h1234);

        // LRU: 0x00 and 0x10 fill set 0, 0x00 touched, 0x20 must evict 0x10
        do_reset();
        do_req(1'b0, 32'h00, 32'h0, h, d, lat);
        do_req(1'b0, 32'h10, 32'h0, h, d, lat);
        do_req(1'b0, 32'h00, 32'h0, h, d, lat);
        check_val("lru_00_hit", {31'h0, h}, 32'h1);
        do_req(1'b0, 32'h20, 32'h0, h, d, lat);
        check_val("lru_20_hit", {31'h0, h}, 32'h0);
        check_val("lru_20_data", d, 32'hB000_0020);
        check_val("lru_memcnt", log_cnt, 32'd3);
        check_val("lru_memaddr", log_addr[2], 32'h20);
        do_req(1'b0, 32'h00, 32'h0, h, d, lat);
        check_val("lru_00_kept", {31'h0, h}, 32'h1);
        check_val("lru_00_data", d, 32'hB000_0000);
        do_req(1'b0, 32'h10, 32'h0, h, d, lat);
        check_val("lru_10_evicted", {31'h0, h}, 32'h0);

        // Dirty eviction: write-back of 0x00 precedes refill of 0x20
        do_reset();
        do_req(1'b1, 32'h00, 32'h55, h, d, lat);
        do_req(1'b1, 32'h10, 32'h66, h, d, lat);
        check_val("wb_pre_memcnt", log_cnt, 32'd0);
        do_req(1'b0, 32'h20, 32'h0, h, d, lat);
        check_val("wb_memcnt", log_cnt, 32'd2);
        check_val("wb_we", {31'h0, log_we[0]}, 32'h1);
        check_val("wb_addr", log_addr[0], 32'h00);
        check_val("wb_data", log_wdata[0], 32'h55);
        check_val("wb_refill_we", {31'h0, log_we[1]}, 32'h0);
        check_val("wb_refill_addr", log_addr[1], 32'h20);
        check_val("wb_rsp_hit", {31'h0, h}, 32'h0);
        check_val("wb_rsp_data", d, 32'hB000_0020);
        do_req(1'b0, 32'h10, 32'h0, h, d, lat);
        check_val("wb_10_kept", d, 32'h66);

        // Memory stall: request held stable, no new CPU requests
        do_reset();
        @(negedge clk);
        mem_req_ready = 1'b0;
        req_valid     = 1'b1;
        req_we        = 1'b0;
        req_addr      = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("stall_valid", {31'h0, mem_req_valid}, 32'h1);
            check_val("stall_addr", mem_req_addr, 32'h10);
            check_val("stall_we", {31'h0, mem_req_we}, 32'h0);
            check_val("stall_req_ready", {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(negedge clk);
        end
        check_val("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check_val("stall_rsp_data", rsp_rdata, 32'h0000_AAAA);
        check_val("stall_rsp_hit", {31'h0, hit}, 32'h0);
        check_val("stall_memcnt", log_cnt, 32'd1);

        // Reset during refill abandons the miss and clears the cached 0x10
        @(negedge clk);
        mem_req_ready = 1'b0;
        req_valid     = 1'b1;
        req_addr      = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("prerst_refill", {31'h0, mem_req_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check_val("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_val("midrst_hit", {31'h0, hit}, 32'h0);
        check_val("midrst_rdata", rsp_rdata, 32'h0);
        check_val("midrst_mem_valid", {31'h0, mem_req_valid}, 32'h0);
        check_val("midrst_mem_we", {31'h0, mem_req_we}, 32'h0);
        check_val("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst           = 1'b0;
        mem_req_ready = 1'b1;
        log_cnt       = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("postrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        do_req(1'b0, 32'h10, 32'h0, h, d, lat);
        check_val("postrst_10_hit", {31'h0, h}, 32'h0);
        check_val("postrst_10_data", d, 32'h0000_AAAA);
        check_val("postrst_memcnt", log_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
